// File: rtl/paint_pkg.sv
// Shared constants, drawer state encoding and coordinate clamp helpers for the paint datapath.
package paint_pkg;

  localparam int unsigned X_MAX = 160;
  localparam int unsigned Y_MAX = 120;
  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StScan  = 2'd2,
    StDone  = 2'd3
  } draw_state_e;

  localparam logic MODE_RECT = 1'b0;
  localparam logic MODE_FREE = 1'b1;

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
    return (v >= XW'(X_MAX)) ? XW'(X_MAX - 1) : v;
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
    return (v >= YW'(Y_MAX)) ? YW'(Y_MAX - 1) : v;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y walker across a rectangle; flags the final pixel so the FSM can stop on it.
module raster_counter
  import paint_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          init_i,
  input  logic          step_i,
  input  logic [XW-1:0] xmin_i,
  input  logic [XW-1:0] xmax_i,
  input  logic [YW-1:0] ymin_i,
  input  logic [YW-1:0] ymax_i,
  output logic [XW-1:0] cx_o,
  output logic [YW-1:0] cy_o,
  output logic          last_o
);

  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (init_i) begin
      cx_d = xmin_i;
      cy_d = ymin_i;
    end else if (step_i) begin
      if (cx_q == xmax_i) begin
        cx_d = xmin_i;
        cy_d = cy_q + YW'(1);
      end else begin
        cx_d = cx_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = (cx_q == xmax_i) && (cy_q == ymax_i);

endmodule

// File: rtl/rect_raster_drawer.sv
// Captures corner/colour loads and, on an enable rising edge, streams the pixels of a filled
// rectangle or a single freeform pixel to the VGA adapter.
module rect_raster_drawer
  import paint_pkg::*;
(
  input  logic          Clock,
  input  logic          reset,
  input  logic [XW-1:0] data_in,
  input  logic [CW-1:0] colour_in,
  input  logic          loadX,
  input  logic          loadY,
  input  logic          loadX2,
  input  logic          loadY2,
  input  logic          loadC,
  input  logic          enable,
  input  logic          alu_select1,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] colour_out,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  draw_state_e state_q, state_d;

  logic [XW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [YW-1:0] y1_q, y1_d, y2_q, y2_d;
  logic [CW-1:0] col_q, col_d, draw_col_q, draw_col_d;
  logic          mode_q, mode_d;
  logic          enable_q;
  logic          plot_q, busy_q, done_q;

  logic          start;
  logic          last;
  logic [XW-1:0] xmin, xmax;
  logic [YW-1:0] ymin, ymax;

  assign start = (state_q == StIdle) && enable && !enable_q;

  // Loads only land while idle so a draw in flight sees stable corners.
  always_comb begin
    x1_d  = x1_q;
    y1_d  = y1_q;
    x2_d  = x2_q;
    y2_d  = y2_q;
    col_d = col_q;
    if (state_q == StIdle) begin
      if (loadX)  x1_d  = clamp_x(data_in);
      if (loadY)  y1_d  = clamp_y(data_in[YW-1:0]);
      if (loadX2) x2_d  = clamp_x(data_in);
      if (loadY2) y2_d  = clamp_y(data_in[YW-1:0]);
      if (loadC)  col_d = colour_in;
    end
  end

  always_comb begin
    if (mode_q == MODE_FREE) begin
      xmin = x1_q;
      xmax = x1_q;
      ymin = y1_q;
      ymax = y1_q;
    end else begin
      xmin = (x1_q < x2_q) ? x1_q : x2_q;
      xmax = (x1_q < x2_q) ? x2_q : x1_q;
      ymin = (y1_q < y2_q) ? y1_q : y2_q;
      ymax = (y1_q < y2_q) ? y2_q : y1_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q    <= StIdle;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      col_q      <= '0;
      draw_col_q <= '0;
      mode_q     <= MODE_RECT;
      enable_q   <= 1'b0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      x2_q       <= x2_d;
      y2_q       <= y2_d;
      col_q      <= col_d;
      draw_col_q <= draw_col_d;
      mode_q     <= mode_d;
      enable_q   <= enable;
      plot_q     <= (state_d == StScan);
      busy_q     <= (state_d == StSetup) || (state_d == StScan);
      done_q     <= (state_d == StDone);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSetup;
      StSetup: state_d = StScan;
      StScan:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d     = start ? alu_select1 : mode_q;
    draw_col_d = (state_q == StSetup) ? col_q : draw_col_q;
  end

  // Stepping stops on the last pixel so x_out/y_out hold it afterwards.
  raster_counter u_raster_counter (
    .clk_i   (Clock),
    .reset_i (reset),
    .init_i  (state_q == StSetup),
    .step_i  ((state_q == StScan) && !last),
    .xmin_i  (xmin),
    .xmax_i  (xmax),
    .ymin_i  (ymin),
    .ymax_i  (ymax),
    .cx_o    (x_out),
    .cy_o    (y_out),
    .last_o  (last)
  );

  assign colour_out = draw_col_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
